// File: rtl/snitch_fpu_share_arb.sv
// snitch_fpu_share_arb: shares one FPU among NumReq cores.
// Issue side: round-robin arbitration with a held grant while the FPU stalls, and
// the winning index prepended to the FPU tag. Each core's in-flight count is bounded.
// Response side: results are steered back to the originating core using the tag index.
// Responses that cannot belong to any in-flight op are sunk and raise a sticky error.
module snitch_fpu_share_arb #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned ReqWidth       = 200,
  parameter int unsigned RspWidth       = 69,
  parameter int unsigned TagWidth       = 4,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxW          = $clog2(NumReq),
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  // Core-side issue
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq*ReqWidth-1:0]   req_data_i,
  input  logic [NumReq*TagWidth-1:0]   req_tag_i,
  // FPU-side issue
  output logic                         fpu_valid_o,
  input  logic                         fpu_ready_i,
  output logic [ReqWidth-1:0]          fpu_data_o,
  output logic [IdxW+TagWidth-1:0]     fpu_tag_o,
  // FPU-side response
  input  logic                         fpu_rsp_valid_i,
  output logic                         fpu_rsp_ready_o,
  input  logic [RspWidth-1:0]          fpu_rsp_data_i,
  input  logic [IdxW+TagWidth-1:0]     fpu_rsp_tag_i,
  // Core-side response
  output logic [NumReq-1:0]            rsp_valid_o,
  input  logic [NumReq-1:0]            rsp_ready_i,
  output logic [RspWidth-1:0]          rsp_data_o,
  output logic [TagWidth-1:0]          rsp_tag_o,
  // Status
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int NR = int'(NumReq);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumReq - 1);

  // State
  logic [IdxW-1:0] rr_q, rr_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [CntW-1:0] cnt_q [NumReq];
  logic [CntW-1:0] cnt_d [NumReq];
  logic            err_q, err_d;

  // Issue-side combinational signals
  logic [NumReq-1:0] elig;
  logic [IdxW-1:0]   scan_idx [NumReq];
  logic [IdxW-1:0]   arb_idx;
  logic              arb_found;
  logic [IdxW-1:0]   gnt;
  logic              issue_hs;
  logic [TagWidth-1:0] sel_tag;

  // Response-side combinational signals
  logic [IdxW-1:0] rsp_idx;
  logic            rsp_idx_ok;
  logic [CntW-1:0] rsp_cnt;
  logic            rsp_rdy_sel;
  logic            rsp_bad;
  logic            rsp_hs;
  logic            any_cnt;

  // A core may compete only while it has room for another in-flight op.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NR; i++) begin
      elig[i] = req_valid_i[i] && (cnt_q[i] < CntMax);
    end
  end

  // Scan order rr_q, rr_q+1, ... wrapped modulo NumReq (NumReq need not be a power of two).
  always_comb begin
    for (int k = 0; k < NR; k++) begin
      if (int'(rr_q) + k >= NR) begin
        scan_idx[k] = IdxW'(int'(rr_q) + k - NR);
      end else begin
        scan_idx[k] = IdxW'(int'(rr_q) + k);
      end
    end
  end

  // Round-robin pick: first eligible core in scan order.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int k = 0; k < NR; k++) begin
      if (!arb_found && elig[scan_idx[k]]) begin
        arb_found = 1'b1;
        arb_idx   = scan_idx[k];
      end
    end
  end

  // Grant, FPU valid and per-core ready; valid never looks at fpu_ready_i.
  always_comb begin
    gnt         = lock_q ? gnt_q : arb_idx;
    fpu_valid_o = lock_q | arb_found;
    issue_hs    = fpu_valid_o & fpu_ready_i;
    req_ready_o = '0;
    for (int i = 0; i < NR; i++) begin
      req_ready_o[i] = issue_hs && (gnt == IdxW'(i));
    end
  end

  // Payload and tag mux for the granted core.
  always_comb begin
    fpu_data_o = '0;
    sel_tag    = '0;
    for (int i = 0; i < NR; i++) begin
      if (gnt == IdxW'(i)) begin
        fpu_data_o = req_data_i[i*ReqWidth +: ReqWidth];
        sel_tag    = req_tag_i[i*TagWidth +: TagWidth];
      end
    end
    fpu_tag_o = {gnt, sel_tag};
  end

  // Decode the response tag and look up the target core's state.
  always_comb begin
    rsp_idx     = fpu_rsp_tag_i[IdxW+TagWidth-1:TagWidth];
    rsp_idx_ok  = 1'b0;
    rsp_cnt     = '0;
    rsp_rdy_sel = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (rsp_idx == IdxW'(i)) begin
        rsp_idx_ok  = 1'b1;
        rsp_cnt     = cnt_q[i];
        rsp_rdy_sel = rsp_ready_i[i];
      end
    end
  end

  // Route the response; orphan responses are accepted unconditionally so the FPU never stalls.
  always_comb begin
    rsp_bad         = fpu_rsp_valid_i && (!rsp_idx_ok || (rsp_cnt == '0));
    rsp_hs          = fpu_rsp_valid_i && !rsp_bad && rsp_rdy_sel;
    fpu_rsp_ready_o = fpu_rsp_valid_i && (rsp_bad || rsp_rdy_sel);
    rsp_valid_o     = '0;
    for (int i = 0; i < NR; i++) begin
      rsp_valid_o[i] = fpu_rsp_valid_i && !rsp_bad && (rsp_idx == IdxW'(i));
    end
    rsp_data_o = fpu_rsp_data_i;
    rsp_tag_o  = fpu_rsp_tag_i[TagWidth-1:0];
  end

  // Outstanding counters: same-cycle issue and response to one core cancel out.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      logic inc;
      logic dec;
      inc      = issue_hs && (gnt == IdxW'(i));
      dec      = rsp_hs && (rsp_idx == IdxW'(i));
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // Pointer, lock and error next-state.
  always_comb begin
    rr_d   = rr_q;
    lock_d = lock_q;
    gnt_d  = gnt_q;
    err_d  = err_q | rsp_bad;
    if (issue_hs) begin
      rr_d   = (gnt == IdxLast) ? '0 : gnt + 1'b1;
      lock_d = 1'b0;
    end else if (fpu_valid_o) begin
      // FPU stalled: hold this grant so the offered payload cannot change under it.
      lock_d = 1'b1;
      gnt_d  = gnt;
    end
  end

  // Busy whenever anything is offered or still in flight.
  always_comb begin
    any_cnt = 1'b0;
    for (int i = 0; i < NR; i++) begin
      any_cnt = any_cnt | (cnt_q[i] != '0);
    end
    busy_o = fpu_valid_o | any_cnt;
    err_o  = err_q;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q   <= '0;
      lock_q <= 1'b0;
      gnt_q  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < NR; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      rr_q   <= rr_d;
      lock_q <= lock_d;
      gnt_q  <= gnt_d;
      err_q  <= err_d;
      for (int i = 0; i < NR; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_snitch_fpu_share_arb.sv
// Scoreboard bench for snitch_fpu_share_arb: stimulus pushes expected FPU issues and
// core responses into queues; a negedge monitor pops and compares on each handshake.
module tb_snitch_fpu_share_arb;

  localparam int NumReq   = 4;
  localparam int ReqWidth = 200;
  localparam int RspWidth = 69;
  localparam int TagWidth = 4;
  localparam int MaxOut   = 4;
  localparam int IdxW     = 2;
  localparam int FTW      = IdxW + TagWidth;

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  logic [NumReq-1:0]          req_valid_i;
  logic [NumReq-1:0]          req_ready_o;
  logic [NumReq*ReqWidth-1:0] req_data_i;
  logic [NumReq*TagWidth-1:0] req_tag_i;
  logic                       fpu_valid_o;
  logic                       fpu_ready_i;
  logic [ReqWidth-1:0]        fpu_data_o;
  logic [FTW-1:0]             fpu_tag_o;
  logic                       fpu_rsp_valid_i;
  logic                       fpu_rsp_ready_o;
  logic [RspWidth-1:0]        fpu_rsp_data_i;
  logic [FTW-1:0]             fpu_rsp_tag_i;
  logic [NumReq-1:0]          rsp_valid_o;
  logic [NumReq-1:0]          rsp_ready_i;
  logic [RspWidth-1:0]        rsp_data_o;
  logic [TagWidth-1:0]        rsp_tag_o;
  logic                       busy_o;
  logic                       err_o;

  snitch_fpu_share_arb #(
    .NumReq         (NumReq),
    .ReqWidth       (ReqWidth),
    .RspWidth       (RspWidth),
    .TagWidth       (TagWidth),
    .MaxOutstanding (MaxOut)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_data_i      (req_data_i),
    .req_tag_i       (req_tag_i),
    .fpu_valid_o     (fpu_valid_o),
    .fpu_ready_i     (fpu_ready_i),
    .fpu_data_o      (fpu_data_o),
    .fpu_tag_o       (fpu_tag_o),
    .fpu_rsp_valid_i (fpu_rsp_valid_i),
    .fpu_rsp_ready_o (fpu_rsp_ready_o),
    .fpu_rsp_data_i  (fpu_rsp_data_i),
    .fpu_rsp_tag_i   (fpu_rsp_tag_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_data_o      (rsp_data_o),
    .rsp_tag_o       (rsp_tag_o),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [FTW-1:0]      iss_tag_q  [$];
  logic [ReqWidth-1:0] iss_data_q [$];
  logic [NumReq-1:0]   rv_q       [$];
  logic [TagWidth-1:0] rt_q       [$];
  logic [RspWidth-1:0] rd_q       [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ReqWidth-1:0] pay(input int core, input logic [3:0] tag);
    logic [ReqWidth-1:0] d;
    logic [3:0]          c;
    c = 4'(core);
    d = '0;
    d[ReqWidth-1 -: 8] = 8'hA0 + 8'(core);
    d[7:0]             = {c, tag};
    d[100 +: 8]        = {tag, ~tag};
    return d;
  endfunction

  function automatic logic [RspWidth-1:0] rpay(input int core, input logic [3:0] tag);
    logic [RspWidth-1:0] r;
    r = '0;
    r[RspWidth-1 -: 5] = 5'(core);
    r[63:0]            = 64'hFEED_0000_0000_0000 | 64'(tag);
    return r;
  endfunction

  task automatic set_req(input int core, input logic v, input logic [3:0] tag);
    req_valid_i[core]                      = v;
    req_tag_i[core*TagWidth +: TagWidth]   = tag;
    req_data_i[core*ReqWidth +: ReqWidth]  = pay(core, tag);
  endtask

  task automatic exp_iss(input int core, input logic [3:0] tag);
    logic [IdxW-1:0] c;
    c = IdxW'(core);
    iss_tag_q.push_back({c, tag});
    iss_data_q.push_back(pay(core, tag));
  endtask

  task automatic exp_rsp(input int core, input logic [3:0] tag);
    logic [NumReq-1:0] v;
    v = '0;
    v[core] = 1'b1;
    rv_q.push_back(v);
    rt_q.push_back(tag);
    rd_q.push_back(rpay(core, tag));
  endtask

  task automatic fpu_rsp(input int idx, input logic [3:0] tag);
    logic [IdxW-1:0] c;
    c = IdxW'(idx);
    fpu_rsp_valid_i = 1'b1;
    fpu_rsp_tag_i   = {c, tag};
    fpu_rsp_data_i  = rpay(idx, tag);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One-cycle valid response from the FPU that the core accepts.
  task automatic do_rsp(input int core, input logic [3:0] tag);
    exp_rsp(core, tag);
    fpu_rsp(core, tag);
    @(negedge clk_i);
    check("rsp_ready_hs", fpu_rsp_ready_o, 1'b1);
    tick();
    fpu_rsp_valid_i = 1'b0;
  endtask

  // Monitor: compares every FPU issue and every core-side response handshake.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (fpu_valid_o && fpu_ready_i) begin
        if (iss_tag_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_issue: got tag %0h expected none", fpu_tag_o);
        end else begin
          logic [FTW-1:0]      et;
          logic [ReqWidth-1:0] ed;
          et = iss_tag_q.pop_front();
          ed = iss_data_q.pop_front();
          check("issue_tag", fpu_tag_o, et);
          check("issue_data", fpu_data_o, ed);
        end
      end
      if (|(rsp_valid_o & rsp_ready_i)) begin
        if (rv_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got valid %0h expected none", rsp_valid_o);
        end else begin
          logic [NumReq-1:0]   ev;
          logic [TagWidth-1:0] etg;
          logic [RspWidth-1:0] edt;
          ev  = rv_q.pop_front();
          etg = rt_q.pop_front();
          edt = rd_q.pop_front();
          check("rsp_valid", rsp_valid_o, ev);
          check("rsp_tag", rsp_tag_o, etg);
          check("rsp_data", rsp_data_o, edt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i           = 1'b1;
    req_valid_i     = '0;
    req_data_i      = '0;
    req_tag_i       = '0;
    fpu_ready_i     = 1'b0;
    fpu_rsp_valid_i = 1'b0;
    fpu_rsp_data_i  = '0;
    fpu_rsp_tag_i   = '0;
    rsp_ready_i     = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_fpu_valid", fpu_valid_o, 1'b0);
    check("rst_req_ready", req_ready_o, 4'h0);
    check("rst_rsp_valid", rsp_valid_o, 4'h0);
    check("rst_rsp_ready", fpu_rsp_ready_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    tick();
    rst_i = 1'b0;
    tick();

    // Round-robin: all cores valid, grant order 0,1,2,3,0,1,2,3
    fpu_ready_i = 1'b1;
    rsp_ready_i = 4'hF;
    for (int c = 0; c < 8; c++) exp_iss(c % 4, 4'(c % 4 + 8));
    for (int i = 0; i < NumReq; i++) set_req(i, 1'b1, 4'(i + 8));
    repeat (8) @(posedge clk_i);
    #1;
    for (int i = 0; i < NumReq; i++) set_req(i, 1'b0, 4'(i + 8));
    @(negedge clk_i);
    check("rr_idle_valid", fpu_valid_o, 1'b0);
    check("rr_busy_inflight", busy_o, 1'b1);
    tick();
    for (int c = 0; c < 8; c++) do_rsp(c % 4, 4'(c % 4 + 8));
    @(negedge clk_i);
    check("rr_drained_busy", busy_o, 1'b0);
    tick();

    // Lock: advance rr_q to 1, then stall with cores 1 and 2 requesting
    exp_iss(0, 4'h1);
    set_req(0, 1'b1, 4'h1);
    tick();
    set_req(0, 1'b0, 4'h1);
    fpu_ready_i = 1'b0;
    set_req(1, 1'b1, 4'h3);
    set_req(2, 1'b1, 4'h6);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("lock_valid", fpu_valid_o, 1'b1);
      check("lock_tag", fpu_tag_o, {2'd1, 4'h3});
      check("lock_ready", req_ready_o, 4'h0);
      tick();
    end
    exp_iss(1, 4'h3);
    exp_iss(2, 4'h6);
    fpu_ready_i = 1'b1;
    @(negedge clk_i);
    check("lock_accept1", req_ready_o, 4'b0010);
    tick();
    set_req(1, 1'b0, 4'h3);
    @(negedge clk_i);
    check("lock_next2", req_ready_o, 4'b0100);
    tick();
    set_req(2, 1'b0, 4'h6);
    do_rsp(0, 4'h1);
    do_rsp(1, 4'h3);
    do_rsp(2, 4'h6);

    // Outstanding limit on core 0 (rr_q is 3 here)
    for (int k = 0; k < MaxOut; k++) exp_iss(0, 4'h5);
    set_req(0, 1'b1, 4'h5);
    repeat (MaxOut) @(posedge clk_i);
    #1;
    set_req(3, 1'b1, 4'h9);
    exp_iss(3, 4'h9);
    @(negedge clk_i);
    check("sat_ready", req_ready_o, 4'b1000);
    check("sat_tag3", fpu_tag_o, {2'd3, 4'h9});
    tick();
    set_req(3, 1'b0, 4'h9);
    @(negedge clk_i);
    check("sat_no_valid", fpu_valid_o, 1'b0);
    tick();
    exp_rsp(0, 4'h5);
    fpu_rsp(0, 4'h5);
    @(negedge clk_i);
    check("sat_rsp_valid", rsp_valid_o, 4'b0001);
    check("sat_rsp_tag", rsp_tag_o, 4'h5);
    check("sat_still_full", fpu_valid_o, 1'b0);
    tick();
    fpu_rsp_valid_i = 1'b0;
    exp_iss(0, 4'h5);
    @(negedge clk_i);
    check("sat_reeligible", req_ready_o, 4'b0001);
    tick();
    set_req(0, 1'b0, 4'h5);

    // Simultaneous issue and response on core 2 at cnt=3
    for (int k = 0; k < 3; k++) exp_iss(2, 4'h2);
    set_req(2, 1'b1, 4'h2);
    repeat (3) @(posedge clk_i);
    #1;
    exp_iss(2, 4'h2);
    exp_rsp(2, 4'h2);
    fpu_rsp(2, 4'h2);
    tick();
    fpu_rsp_valid_i = 1'b0;
    exp_iss(2, 4'h2);
    tick();
    @(negedge clk_i);
    check("sim_cnt_full", fpu_valid_o, 1'b0);
    tick();
    set_req(2, 1'b0, 4'h2);

    // Response backpressure on core 3
    rsp_ready_i = 4'b0111;
    fpu_rsp(3, 4'h9);
    @(negedge clk_i);
    check("bp_rsp_valid", rsp_valid_o, 4'b1000);
    check("bp_rsp_ready", fpu_rsp_ready_o, 1'b0);
    tick();
    rsp_ready_i = 4'hF;
    do_rsp(3, 4'h9);

    // Error: response to core 1 with nothing outstanding
    rsp_ready_i = 4'h0;
    fpu_rsp(1, 4'h3);
    @(negedge clk_i);
    check("err_forced_ready", fpu_rsp_ready_o, 1'b1);
    check("err_no_valid", rsp_valid_o, 4'h0);
    check("err_not_yet", err_o, 1'b0);
    tick();
    fpu_rsp_valid_i = 1'b0;
    rsp_ready_i = 4'hF;
    @(negedge clk_i);
    check("err_set", err_o, 1'b1);
    repeat (3) tick();
    @(negedge clk_i);
    check("err_sticky", err_o, 1'b1);
    tick();

    // Reset mid-lock with counters 0 and 2 saturated
    fpu_ready_i = 1'b0;
    set_req(3, 1'b1, 4'hC);
    tick();
    @(negedge clk_i);
    check("pre_rst_lock_tag", fpu_tag_o, {2'd3, 4'hC});
    check("pre_rst_busy", busy_o, 1'b1);
    #2;
    rst_i = 1'b1;
    set_req(3, 1'b0, 4'hC);
    #1;
    check("rst_mid_busy", busy_o, 1'b0);
    check("rst_mid_valid", fpu_valid_o, 1'b0);
    check("rst_mid_err", err_o, 1'b0);
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_busy", busy_o, 1'b0);
    tick();
    // Lock and counters cleared: core 0 wins from rr_q=0, then core 3
    fpu_ready_i = 1'b1;
    exp_iss(0, 4'h7);
    exp_iss(3, 4'hC);
    set_req(0, 1'b1, 4'h7);
    set_req(3, 1'b1, 4'hC);
    tick();
    set_req(0, 1'b0, 4'h7);
    tick();
    set_req(3, 1'b0, 4'hC);

    // Stale FPU result for core 2 after reset
    fpu_rsp(2, 4'h1);
    @(negedge clk_i);
    check("stale_ready", fpu_rsp_ready_o, 1'b1);
    check("stale_no_valid", rsp_valid_o, 4'h0);
    tick();
    fpu_rsp_valid_i = 1'b0;
    @(negedge clk_i);
    check("stale_err", err_o, 1'b1);
    tick();
    do_rsp(0, 4'h7);
    do_rsp(3, 4'hC);
    @(negedge clk_i);
    check("final_busy", busy_o, 1'b0);
    check("iss_queue_empty", iss_tag_q.size(), 0);
    check("rsp_queue_empty", rv_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snitch_fpu_share_arb.md
# snitch_fpu_share_arb

Shares one FPU instance among `NumReq` cores. It arbitrates issue requests round-robin and prepends the requester index to the FPU tag. Each core's outstanding operations are bounded. Responses returning from the FPU are routed back to the originating core by tag. The block sits between the core-side FPU request/response ports and the single FPU synthesis wrapper of a cluster tile.

## Interface
Parameters:
- `NumReq`, 4, number of sharing cores; must be ≥ 2.
- `ReqWidth`, 200, width of the opaque request payload (operands, op, formats, round mode).
- `RspWidth`, 69, width of the opaque response payload (result + status).
- `TagWidth`, 4, per-core tag width; FPU-side tag width is `IdxW+TagWidth`, where `IdxW = $clog2(NumReq)`.
- `MaxOutstanding`, 4, per-core in-flight limit, ≥ 1; counter width `CntW = $clog2(MaxOutstanding+1)`.

Ports:
- `clk_i`  in  1  clock; all state on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  NumReq  per-core issue valid.
- `req_ready_o`  out  NumReq  per-core issue ready.
- `req_data_i`  in  NumReq×ReqWidth  per-core payload.
- `req_tag_i`  in  NumReq×TagWidth  per-core tag.
- `fpu_valid_o`  out  1  issue valid to the FPU.
- `fpu_ready_i`  in  1  FPU issue ready.
- `fpu_data_o`  out  ReqWidth  granted payload.
- `fpu_tag_o`  out  IdxW+TagWidth  `{grant index, req_tag}`.
- `fpu_rsp_valid_i`  in  1  FPU result valid.
- `fpu_rsp_ready_o`  out  1  FPU result ready.
- `fpu_rsp_data_i`  in  RspWidth  FPU result payload.
- `fpu_rsp_tag_i`  in  IdxW+TagWidth  FPU result tag.
- `rsp_valid_o`  out  NumReq  per-core result valid.
- `rsp_ready_i`  in  NumReq  per-core result ready.
- `rsp_data_o`  out  RspWidth  broadcast result payload.
- `rsp_tag_o`  out  TagWidth  low `TagWidth` bits of `fpu_rsp_tag_i`.
- `busy_o`  out  1  any operation in flight or pending issue.
- `err_o`  out  1  sticky protocol error flag.

## Operation
State:
- `rr_q`: round-robin pointer, IdxW bits.
- `lock_q` and `gnt_q`: held grant.
- `cnt_q[NumReq]`: outstanding counters.
- `err_q`: sticky error flag.

Issue:
- A core is eligible when `req_valid_i[i] && cnt_q[i] < MaxOutstanding`.
- Unlocked: grant the first eligible index scanning `rr_q, rr_q+1, …` modulo NumReq.
- `fpu_valid_o` = any eligible core (unlocked) or 1 (locked).
- `req_ready_o[gnt] = fpu_ready_i`; all other ready bits are 0.
- Lock: if `fpu_valid_o && !fpu_ready_i`, then `lock_q <= 1` and `gnt_q <= gnt`. While locked, the grant is `gnt_q` regardless of other requests. Cores must hold valid, data and tag stable until accepted.
- Issue handshake (`fpu_valid_o && fpu_ready_i`): `rr_q <= gnt+1` (wraps to 0 at NumReq), `lock_q <= 0`, `cnt_q[gnt]++`.

Response:
- `idx = fpu_rsp_tag_i[IdxW+TagWidth-1:TagWidth]`.
- `rsp_valid_o[idx] = fpu_rsp_valid_i`; all other valid bits are 0.
- `fpu_rsp_ready_o = rsp_ready_i[idx]`.
- Response handshake: `cnt_q[idx]--`.
- Invalid `idx` (≥ NumReq) or `cnt_q[idx]==0`: force `fpu_rsp_ready_o=1`, drive no `rsp_valid_o`, leave counters unchanged, set `err_q`.

Boundaries:
- Issue and response to the same core in the same cycle: counter unchanged.
- Counter saturates at `MaxOutstanding`; that core becomes ineligible until a response drains.
- `busy_o = fpu_valid_o || (|cnt_q)`.

## Timing
- Reset (async assert, any cycle, including mid-transaction): `rr_q=0`, `lock_q=0`, `gnt_q=0`, all `cnt_q=0`, `err_q=0`.
- During and after reset, all valid/ready outputs are 0 until requests arrive. `err_o=0`, `busy_o=0`. In-flight FPU results arriving after reset are flagged as errors.
- Latency is zero cycles in both directions: request to `fpu_valid_o`, and FPU result to `rsp_valid_o`, are combinational.
- Paths `fpu_ready_i` → `req_ready_o` and `rsp_ready_i` → `fpu_rsp_ready_o` are combinational.
- No combinational path from `fpu_ready_i` to `fpu_valid_o`.
- Counters, pointer and lock update on the clock edge after the handshake.
- Full throughput: one issue and one response per cycle.

## Test plan
- **Round-robin:** all 4 cores valid continuously, `fpu_ready_i=1`, responses returned promptly → grant order 0,1,2,3,0,…; `fpu_tag_o` upper bits match the grant.
- **Lock:** cores 1 and 2 valid, `rr_q=1`, `fpu_ready_i=0` for 3 cycles → grant stays 1 all 3 cycles; on ready, core 1 accepted, next grant is 2.
- **Outstanding limit:** core 0 issues 4 ops with no responses → `req_ready_o[0]=0` and core 3 is granted; one response tagged `{0,5}` → `rsp_valid_o[0]=1`, `rsp_tag_o=5`, core 0 eligible again.
- **Simultaneous events:** same-cycle issue and response for core 2 with `cnt=3` → cnt stays 3.
- **Error:** response with `idx=1` while `cnt_q[1]=0` → `fpu_rsp_ready_o=1`, no `rsp_valid_o`, `err_o=1` and it stays 1.
- **Reset:** assert `rst_i` mid-lock with counters nonzero → next cycle all counters 0, `lock_q=0`, `busy_o=0`.
